// File: rtl/cond_pkg.sv
// Shared types for the flag/condition unit: branch kinds, ARM condition codes
// and the packed NZCV flag word.
// Imported by cond_eval and flag_cond_unit.
package cond_pkg;

  localparam int MAX_PENDING_DEF = 3;

  typedef enum logic [1:0] {
    BR_B    = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_kind_t;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator.
// Ports: flags (NZCV in), cond (condition code in), taken (condition holds, out).
// Zero latency; no state, no flow control.
module cond_eval
  import cond_pkg::*;
(
  input  nzcv_t flags,
  input  cond_t cond,
  output logic  taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      EQ: taken = flags.z;
      NE: taken = !flags.z;
      HS: taken = flags.c;
      LO: taken = !flags.c;
      MI: taken = flags.n;
      PL: taken = !flags.n;
      VS: taken = flags.v;
      VC: taken = !flags.v;
      HI: taken = flags.c & !flags.z;
      LS: taken = !flags.c | flags.z;
      GE: taken = (flags.n == flags.v);
      LT: taken = (flags.n != flags.v);
      GT: taken = !flags.z & (flags.n == flags.v);
      LE: taken = flags.z | (flags.n != flags.v);
      AL: taken = 1'b1;
      NV: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural NZCV register plus branch resolver with a pending-flag-writer
// scoreboard that stalls B.cond until every in-flight ADDS/SUBS has written back.
// Ports: issue_fw/issue_ready (writer issue), alu_* (flag writeback),
//        br_* (branch request, valid/ready), resp_* (resolution, valid/ready), flags_q.
// Latency: accepted branch -> response one cycle later; response held under backpressure.
module flag_cond_unit
  import cond_pkg::*;
#(
  parameter int MAX_PENDING = MAX_PENDING_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_fw,
  output logic       issue_ready,
  input  logic       alu_valid,
  input  logic       alu_set_flags,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  input  logic       br_valid,
  output logic       br_ready,
  input  logic [1:0] br_kind,
  input  logic [3:0] br_cond,
  input  logic       br_op_zero,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_taken,
  output logic [3:0] flags_q
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [PW-1:0] pend_cnt;
  nzcv_t         flags_r;
  nzcv_t         alu_flags;
  nzcv_t         eff_flags;
  br_kind_t      kind;
  logic          flag_wr;
  logic          issue_acc;
  logic          slot_free;
  logic          cond_clear;
  logic          br_acc;
  logic          cond_taken;
  logic          taken_next;

  assign alu_flags = '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow};
  assign flag_wr   = alu_valid & alu_set_flags;
  assign issue_ready = (pend_cnt < PW'(MAX_PENDING));
  assign issue_acc = issue_fw & issue_ready;

  // Forward this cycle's ALU flags so a branch can resolve alongside the last writer.
  assign eff_flags = flag_wr ? alu_flags : flags_r;

  // A B.cond may go once nothing is pending, or when the sole pending writer
  // retires this very cycle and no new writer is slipping in behind it.
  assign cond_clear = (pend_cnt == '0) |
                      ((pend_cnt == PW'(1)) & flag_wr & !issue_acc);
  assign slot_free  = !resp_valid | resp_ready;
  assign kind       = br_kind_t'(br_kind);
  assign br_ready   = slot_free & ((kind != BR_COND) | cond_clear);
  assign br_acc     = br_valid & br_ready;

  cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (cond_t'(br_cond)),
    .taken (cond_taken)
  );

  always_comb begin
    taken_next = 1'b1;
    case (kind)
      BR_B:    taken_next = 1'b1;
      BR_COND: taken_next = cond_taken;
      BR_CBZ:  taken_next = br_op_zero;
      BR_CBNZ: taken_next = !br_op_zero;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_r    <= '0;
      pend_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_taken <= 1'b0;
    end else begin
      if (flag_wr) begin
        flags_r <= alu_flags;
      end

      // Simultaneous issue and writeback cancel; a stray writeback at zero
      // updates the flags but must not wrap the count.
      case ({issue_acc, flag_wr})
        2'b10: pend_cnt <= pend_cnt + PW'(1);
        2'b01: if (pend_cnt != '0) pend_cnt <= pend_cnt - PW'(1);
        default: ;
      endcase

      if (br_acc) begin
        resp_valid <= 1'b1;
        resp_taken <= taken_next;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  assign flags_q = flags_r;

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_fw;
  logic       issue_ready;
  logic       alu_valid;
  logic       alu_set_flags;
  logic       alu_negative;
  logic       alu_zero;
  logic       alu_carry_out;
  logic       alu_overflow;
  logic       br_valid;
  logic       br_ready;
  logic [1:0] br_kind;
  logic [3:0] br_cond;
  logic       br_op_zero;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_taken;
  logic [3:0] flags_q;

  int total = 0;
  int bad   = 0;

  // Reference state: what the architectural registers must hold right now.
  bit       known = 0;
  bit [3:0] m_flags;
  int       m_pend;
  bit       m_rv;
  bit       m_rt;
  localparam int MAXP = 3;

  always #5 clk = ~clk;

  flag_cond_unit dut (
    .clk           (clk),
    .reset         (reset),
    .issue_fw      (issue_fw),
    .issue_ready   (issue_ready),
    .alu_valid     (alu_valid),
    .alu_set_flags (alu_set_flags),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .alu_carry_out (alu_carry_out),
    .alu_overflow  (alu_overflow),
    .br_valid      (br_valid),
    .br_ready      (br_ready),
    .br_kind       (br_kind),
    .br_cond       (br_cond),
    .br_op_zero    (br_op_zero),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_taken    (resp_taken),
    .flags_q       (flags_q)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM-style evaluation: the upper three bits pick a base test, bit 0 inverts
  // it (except for the always pair).
  function automatic bit m_cond(input bit [3:0] f, input int cc);
    bit n = f[3];
    bit z = f[2];
    bit c = f[1];
    bit v = f[0];
    bit r;
    case (cc / 2)
      0: r = z;
      1: r = c;
      2: r = n;
      3: r = v;
      4: r = c && !z;
      5: r = (n == v);
      6: r = (n == v) && !z;
      default: r = 1;
    endcase
    if ((cc % 2 == 1) && (cc / 2 != 7)) r = !r;
    return r;
  endfunction

  function automatic bit m_br_ready();
    bit fw   = alu_valid && alu_set_flags;
    bit iacc = issue_fw && (m_pend < MAXP);
    bit free = !m_rv || resp_ready;
    if (br_kind != 2'b01) return free;
    return free && (m_pend == 0 || (m_pend == 1 && fw && !iacc));
  endfunction

  // Compare current outputs to the model, then advance the model across the edge.
  task automatic tick();
    bit       fw;
    bit       iacc;
    bit       acc;
    bit [3:0] eff;
    bit       tk;
    #1;
    if (known) begin
      chk("flags_q", flags_q, m_flags);
      chk("issue_ready", issue_ready, (m_pend < MAXP));
      chk("resp_valid", resp_valid, m_rv);
      if (m_rv) chk("resp_taken", resp_taken, m_rt);
      chk("br_ready", br_ready, m_br_ready());
    end
    fw   = alu_valid && alu_set_flags;
    iacc = issue_fw && (m_pend < MAXP);
    eff  = fw ? {alu_negative, alu_zero, alu_carry_out, alu_overflow} : m_flags;
    acc  = br_valid && m_br_ready();
    case (br_kind)
      2'b00: tk = 1;
      2'b01: tk = m_cond(eff, int'(br_cond));
      2'b10: tk = br_op_zero;
      default: tk = !br_op_zero;
    endcase
    if (!reset) begin
      known   = 1;
      m_flags = 0;
      m_pend  = 0;
      m_rv    = 0;
      m_rt    = 0;
    end else if (known) begin
      m_flags = eff;
      m_pend  = m_pend + int'(iacc) - int'(fw);
      if (m_pend < 0) m_pend = 0;
      if (acc) begin
        m_rv = 1;
        m_rt = tk;
      end else if (resp_ready) begin
        m_rv = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    issue_fw = 0; alu_valid = 0; alu_set_flags = 0;
    {alu_negative, alu_zero, alu_carry_out, alu_overflow} = 4'b0000;
    br_valid = 0; br_kind = 2'b00; br_cond = 4'h0; br_op_zero = 0;
    resp_ready = 1;
  endtask

  task automatic wr(input bit [3:0] f);
    alu_valid = 1; alu_set_flags = 1;
    {alu_negative, alu_zero, alu_carry_out, alu_overflow} = f;
  endtask

  initial begin
    idle();
    // 1. reset held two cycles with random inputs
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      {issue_fw, alu_valid, alu_set_flags, br_valid, resp_ready} = 5'($urandom);
      {alu_negative, alu_zero, alu_carry_out, alu_overflow} = 4'($urandom);
      br_kind = 2'($urandom); br_cond = 4'($urandom);
      tick();
    end
    reset = 1; idle();
    #1;
    chk("rst_flags", flags_q, 4'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_taken", resp_taken, 1'b0);
    chk("rst_issue_ready", issue_ready, 1'b1);

    // 2. forwarding: LT resolved in the same cycle as the last flag write
    issue_fw = 1; tick();
    idle(); wr(4'b1000);
    br_valid = 1; br_kind = 2'b01; br_cond = 4'hB;
    #1 chk("fwd_br_ready", br_ready, 1'b1);
    tick();
    chk("fwd_resp_valid", resp_valid, 1'b1);
    chk("fwd_resp_taken", resp_taken, 1'b1);
    chk("fwd_flags", flags_q, 4'b1000);
    idle(); tick();

    // 3. stall EQ behind two pending writers
    issue_fw = 1; tick(); tick();
    idle(); br_valid = 1; br_kind = 2'b01; br_cond = 4'h0;
    #1 chk("stall_pend2", br_ready, 1'b0);
    tick();
    wr(4'b0000);
    #1 chk("stall_wr1", br_ready, 1'b0);
    tick();
    wr(4'b0100);
    #1 chk("stall_wr2", br_ready, 1'b1);
    tick();
    chk("stall_taken", resp_taken, 1'b1);
    idle(); tick();

    // 4. backpressure: GE taken then held while resp_ready=0
    br_valid = 1; br_kind = 2'b01; br_cond = 4'hA; tick();
    resp_ready = 0; br_cond = 4'hB;
    #1 chk("bp_br_ready", br_ready, 1'b0);
    tick();
    chk("bp_hold_valid", resp_valid, 1'b1);
    chk("bp_hold_taken", resp_taken, 1'b1);
    resp_ready = 1;
    #1 chk("bp_release_ready", br_ready, 1'b1);
    tick();
    chk("bp_next_valid", resp_valid, 1'b1);
    chk("bp_next_taken", resp_taken, 1'b0);
    idle(); tick();

    // 5. scoreboard limits
    issue_fw = 1; tick(); tick(); tick();
    chk("sb_full", issue_ready, 1'b0);
    tick();                       // ignored fourth issue
    idle(); wr(4'b0000); tick();
    chk("sb_after_wr", issue_ready, 1'b1);
    issue_fw = 1; tick();         // issue + write: stays at 2
    chk("sb_same_cycle", issue_ready, 1'b1);
    idle(); issue_fw = 1; tick();
    chk("sb_full_again", issue_ready, 1'b0);
    idle(); wr(4'b0010);
    for (int i = 0; i < 4; i++) tick();   // last write lands at zero
    idle(); br_valid = 1; br_kind = 2'b01; br_cond = 4'hE;
    #1 chk("sb_no_underflow", br_ready, 1'b1);
    tick();
    idle(); tick();

    // 6. exhaustive condition codes against the model
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        idle(); wr(4'(f));
        br_valid = 1; br_kind = 2'b01; br_cond = 4'(c);
        tick();
      end
    end
    idle(); tick();
    issue_fw = 1; tick(); tick();
    idle(); br_valid = 1; br_kind = 2'b10; br_op_zero = 1;
    #1 chk("cbz_nostall", br_ready, 1'b1);
    tick(); chk("cbz_z1", resp_taken, 1'b1);
    br_kind = 2'b11; tick(); chk("cbnz_z1", resp_taken, 1'b0);
    br_op_zero = 0; tick(); chk("cbnz_z0", resp_taken, 1'b1);
    br_kind = 2'b10; tick(); chk("cbz_z0", resp_taken, 1'b0);
    br_kind = 2'b00; tick(); chk("b_pend2", resp_taken, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 63) != 0);
      issue_fw      = ($urandom_range(0, 2) == 0);
      alu_valid     = ($urandom_range(0, 2) == 0);
      alu_set_flags = ($urandom_range(0, 3) != 0);
      {alu_negative, alu_zero, alu_carry_out, alu_overflow} = 4'($urandom);
      br_valid      = 1'($urandom);
      br_kind       = 2'($urandom);
      br_cond       = 4'($urandom);
      br_op_zero    = 1'($urandom);
      resp_ready    = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
